// File: rtl/ifetch_queue.sv
// ifetch_queue: sequential instruction fetch with redirect, stale-response drop and PC-tagged FIFO; define IFQ_BYPASS_EN for zero-latency response bypass
module ifetch_queue #(
    parameter int                DEPTH   = 4,
    parameter int                ADDR_W  = 64,
    parameter logic [ADDR_W-1:0] PC_INIT = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]       fifo_inst [DEPTH];
    logic [ADDR_W-1:0] fifo_pc   [DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count, outst, drop, outst_after;
    logic [ADDR_W-1:0] fetch_pc, rsp_pc, tgt;
    logic              empty, credit, accept, rsp, keep, byp, byp_take, push, pop;

    // Request credit, response retirement, bypass and FIFO head selection
    always_comb begin
        empty         = count == '0;
        tgt           = redirect_pc & ~ADDR_W'(3);
        credit        = int'(count) + int'(outst) < DEPTH;
        mem_req_valid = !rst && !redirect_valid && credit;
        mem_req_addr  = fetch_pc;
        accept        = mem_req_valid && mem_req_ready;
        rsp           = mem_rsp_valid && outst != '0;
        keep          = rsp && drop == '0;
`ifdef IFQ_BYPASS_EN
        byp           = keep && empty && !redirect_valid;
`else
        byp           = 1'b0;
`endif
        inst_valid    = !rst && (!empty || byp);
        inst          = rst ? '0 : !empty ? fifo_inst[rd_ptr] : byp ? mem_rsp_data : '0;
        inst_pc       = rst ? '0 : !empty ? fifo_pc[rd_ptr] : byp ? rsp_pc : '0;
        byp_take      = byp && inst_ready;
        pop           = !empty && inst_ready && !redirect_valid;
        push          = keep && !redirect_valid && !byp_take;
        outst_after   = outst - CW'(rsp);
    end

    // PCs, pointers and in-flight tracking; a redirect flushes the FIFO and marks every older in-flight word for dropping
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= PC_INIT;
            rsp_pc   <= PC_INIT;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            outst    <= '0;
            drop     <= '0;
        end else begin
            fetch_pc <= redirect_valid ? tgt : accept ? fetch_pc + ADDR_W'(4) : fetch_pc;
            rsp_pc   <= redirect_valid ? tgt : keep ? rsp_pc + ADDR_W'(4) : rsp_pc;
            rd_ptr   <= redirect_valid ? '0 : rd_ptr + PW'(pop);
            wr_ptr   <= redirect_valid ? '0 : wr_ptr + PW'(push);
            count    <= redirect_valid ? '0 : count + CW'(push) - CW'(pop);
            outst    <= outst_after + CW'(accept);
            drop     <= redirect_valid ? outst_after : drop - CW'(rsp && drop != '0);
        end
    end

    // Entry storage is only read when occupied, so it carries no reset
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst[wr_ptr] <= mem_rsp_data;
            fifo_pc[wr_ptr]   <= rsp_pc;
        end
    end

    // A response with nothing in flight is a memory protocol error
    always_ff @(posedge clk) begin
        if (!rst && mem_rsp_valid)
            assert (outst != '0);
    end
endmodule
